// File: rtl/uart_tx.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// Bit timing comes from an internal bit-period counter clocked by the system clock.
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 32'd50000000,
  parameter int unsigned BAUD      = 32'd9600,
  parameter int unsigned PARITY    = 32'd0,
  parameter int unsigned STOP_BITS = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic parity_of(input logic [7:0] b);
    logic p;
    case (PARITY)
      32'd1:   p = ~^b;
      32'd2:   p = ^b;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             par_r, par_s;
  logic             txd_r, txd_s;
  logic             busy_r, done_r;
  logic             bit_end_s;

  // State, datapath and output registers; outputs are computed from next state so txd is glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      par_r   <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      txd_r   <= txd_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE);
    end
  end

  // Next-state, bit timing and next line level
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    par_s     = par_r;
    txd_s     = 1'b1;
    bit_end_s = (cnt_r == CNT_LAST);

    case (state_r)
      S_IDLE: begin
        cnt_s = '0;
        if (send) begin
          state_s = S_START;
          shift_s = data;
          par_s   = parity_of(data);
          idx_s   = 3'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_s = S_DATA;
          cnt_s   = '0;
          idx_s   = 3'd0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          shift_s = {1'b0, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            idx_s   = 3'd0;
            state_s = (PARITY != 32'd0) ? S_PARITY : S_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_s = S_STOP;
          cnt_s   = '0;
          idx_s   = 3'd0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_STOP: begin
        // idx_r counts stop bits so the bit counter still wraps every bit period
        if (bit_end_s) begin
          cnt_s = '0;
          if (idx_r == STOP_LAST) begin
            idx_s   = 3'd0;
            state_s = S_DONE;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase

    case (state_s)
      S_START:  txd_s = 1'b0;
      S_DATA:   txd_s = shift_s[0];
      S_PARITY: txd_s = par_s;
      default:  txd_s = 1'b1;
    endcase
  end

  assign txd  = txd_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (no/odd/even parity) at 4 clocks per bit,
// line monitors decode frames and compare against bytes queued by the stimulus.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_a [3];
  logic [7:0] data_a [3];
  logic       txd_a  [3];
  logic       busy_a [3];
  logic       done_a [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 10 : 11;
    logic [7:0] exp_q [$];

    uart_tx #(.CLK_FREQ(40), .BAUD(10), .PARITY(g), .STOP_BITS(1)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .send (send_a[g]),
      .data (data_a[g]),
      .txd  (txd_a[g]),
      .busy (busy_a[g]),
      .done (done_a[g])
    );

    task automatic step(input int n, inout bit ab);
      repeat (n) begin
        if (!ab) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
      end
    endtask

    // Line monitor: decode each frame at mid-bit and check it against the queued byte
    initial begin : mon
      logic [7:0] exp_b, got_b;
      logic st_v, stb_v, stop_v, pre_v, done_v, busy_v, txdd_v;
      int ones;
      bit ab;
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (txd_a[g] == 1'b1) begin
            chk($sformatf("dut%0d_idle_busy", g), busy_a[g], 1'b0);
            chk($sformatf("dut%0d_idle_done", g), done_a[g], 1'b0);
          end else begin
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL dut%0d_unexpected_frame: frame started, none expected", g);
              exp_b = 8'h00;
            end else begin
              exp_b = exp_q.pop_front();
            end
            ab = 1'b0;
            got_b = 8'h00;
            step(2, ab);
            st_v  = txd_a[g];
            stb_v = busy_a[g];
            for (int k = 0; k < 8; k++) begin
              step(CPB, ab);
              got_b[k] = txd_a[g];
            end
            for (int k = 0; k < NB - 10; k++) begin
              step(CPB, ab);
              ones = $countones(exp_b);
              if (!ab)
                chk($sformatf("dut%0d_parity", g), txd_a[g],
                    (g == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1));
            end
            step(CPB, ab);
            stop_v = txd_a[g];
            step(1, ab);
            pre_v = done_a[g];
            step(1, ab);
            done_v = done_a[g];
            busy_v = busy_a[g];
            txdd_v = txd_a[g];
            if (!ab) begin
              chk($sformatf("dut%0d_start", g), st_v, 1'b0);
              chk($sformatf("dut%0d_start_busy", g), stb_v, 1'b1);
              chk($sformatf("dut%0d_byte", g), got_b, exp_b);
              chk($sformatf("dut%0d_stop", g), stop_v, 1'b1);
              chk($sformatf("dut%0d_done_early", g), pre_v, 1'b0);
              chk($sformatf("dut%0d_done", g), done_v, 1'b1);
              chk($sformatf("dut%0d_done_busy", g), busy_v, 1'b1);
              chk($sformatf("dut%0d_done_txd", g), txdd_v, 1'b1);
            end
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    case (i)
      0: g_dut[0].exp_q.push_back(b);
      1: g_dut[1].exp_q.push_back(b);
      2: g_dut[2].exp_q.push_back(b);
      default: ;
    endcase
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (busy_a[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL dut%0d_idle_timeout: busy still 1 after %0d cycles, required 0", i, n);
    end
  endtask

  task automatic send_byte(input int i, input logic [7:0] b);
    wait_idle(i);
    data_a[i] = b;
    send_a[i] = 1'b1;
    push(i, b);
    @(negedge clk);
    send_a[i] = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n;
    int gap;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_a[i] = 1'b0;
      data_a[i] = 8'h00;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_txd", txd_a[i], 1'b1);
      chk("reset_busy", busy_a[i], 1'b0);
      chk("reset_done", done_a[i], 1'b0);
    end
    rst = 1'b0;
    repeat (100) @(negedge clk);

    send_byte(0, 8'hA5);
    send_byte(1, 8'h03);
    send_byte(2, 8'h03);
    send_byte(2, 8'h07);
    for (int r = 0; r < 9; r++) send_byte(r % 3, 8'($urandom));

    // Back-to-back with send held high
    wait_idle(0);
    data_a[0] = 8'h00;
    send_a[0] = 1'b1;
    push(0, 8'h00);
    @(negedge clk);
    data_a[0] = 8'hFF;
    push(0, 8'hFF);
    n = 0;
    while (!done_a[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done_seen", done_a[0], 1'b1);
    gap = 1;
    @(negedge clk);
    while (txd_a[0] && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    send_a[0] = 1'b0;
    chk("b2b_gap", gap, 2);

    // Data changed during the start bit must not reach the line
    wait_idle(0);
    data_a[0] = 8'h3C;
    send_a[0] = 1'b1;
    push(0, 8'h3C);
    @(negedge clk);
    send_a[0] = 1'b0;
    data_a[0] = 8'hC3;

    // Reset during data bit 3
    wait_idle(0);
    data_a[0] = 8'($urandom);
    send_a[0] = 1'b1;
    push(0, data_a[0]);
    @(negedge clk);
    send_a[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_reset_busy", busy_a[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midreset_txd", txd_a[0], 1'b1);
    chk("midreset_busy", busy_a[0], 1'b0);
    chk("midreset_done", done_a[0], 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    send_byte(0, 8'h5A);

    for (int r = 0; r < 6; r++) send_byte(r % 3, 8'($urandom));

    for (int i = 0; i < 3; i++) wait_idle(i);
    repeat (10) @(negedge clk);
    chk("dut0_pending", g_dut[0].exp_q.size(), 0);
    chk("dut1_pending", g_dut[1].exp_q.size(), 0);
    chk("dut2_pending", g_dut[2].exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-level UART transmitter that serialises one 8-bit word per request onto the TX pin: start bit, 8 data bits LSB first, optional parity, stop bit(s).
- Sits directly downstream of the byte-sequencing controller that walks the 320-bit report vector. That controller drives send/data and waits on done before presenting the next byte.
- All timing is derived from a single system clock through an internal baud divider.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), default 5208. Must be at least 2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- send  input  1  transmit request; level-sampled in IDLE only.
- data  input  8  byte to transmit; captured on the accept edge.
- txd  output  1  serial line, idle high.
- busy  output  1  high from the accept edge until the end of the DONE cycle.
- done  output  1  single-cycle pulse: the frame has completed, including its final stop bit.

Behaviour:
- Reset (asynchronous, while rst=1): state IDLE, txd=1, busy=0, done=0, baud counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame immediately; txd returns high without waiting for a clock edge.
- States and transitions:
  - IDLE: txd=1, busy=0. On a rising edge with send=1, latch data into the shift register, compute parity from the latched byte, and go to START. This is the accept edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit; then shift right and increment the bit index. After bit 7, go to PARITY if PARITY!=0, otherwise to STOP.
  - PARITY: txd=parity bit for CLKS_PER_BIT cycles. Odd mode: the bit makes the count of ones across data plus parity odd (~^byte). Even mode: ^byte. Then go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to DONE.
  - DONE: exactly one cycle; done=1, busy=1, txd=1; send is ignored. Next state is IDLE.
- Latency and timing:
  - txd falls in the first cycle after the accept edge.
  - Frame length (start to end of stop) = (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 if PARITY!=0.
  - done is high in the cycle immediately after the last stop-bit cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and clears on every bit boundary and on every state change.
  - Width is $clog2(CLKS_PER_BIT).
- Handshake rules:
  - data and send are don't-care outside IDLE. Changing data mid-frame must not alter the frame in flight.
  - send held high continuously yields back-to-back frames separated by exactly 2 idle-high cycles (the DONE cycle plus the IDLE accept cycle). No frame may be dropped or duplicated.
  - If send drops in the same cycle that done is high, no new frame starts.
- Outputs are registered; txd must be glitch-free.

Test Plan:
- Reset: hold rst=1, then release with send=0 -> txd=1, busy=0, done=0; no activity for 100 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY=0, send 8'hA5 (one-cycle pulse) -> txd from accept+1 is 0,1,0,1,0,0,1,0,1,1, each for 4 cycles. done is high for exactly 1 cycle, 40 cycles after the first start-bit cycle; busy stays high through that cycle.
- Parity: PARITY=1 with byte 8'h03 -> parity bit 1. PARITY=2 with 8'h03 -> 0. PARITY=2 with 8'h07 -> 1. Frame is 11 bit-times.
- Back-to-back: hold send=1 with data 8'h00 then 8'hFF (data switched after the first accept) -> two complete frames, a 2-cycle high gap between them, two done pulses, second frame carries 8'hFF.
- Reset mid-frame: assert rst during data bit 3 -> txd=1 and busy=0 asynchronously, no done pulse. After release, a new send of 8'h5A transmits correctly from its start bit.
- Data change mid-frame: accept 8'h3C, then drive data=8'hC3 during the start bit -> line carries 8'h3C.
